// File: rtl/axil_core_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axil_core_master_bridge
// Description : Bridges single-beat load/store requests from the RV32I core
//               data port onto an AXI4-Lite master interface. Only one
//               transaction is outstanding at a time, and all AXI outputs
//               come straight from flops.
//               Optional build macro AXIL_ADDR_CHECK_EN enables local
//               rejection of misaligned or out-of-window addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_core_master_bridge #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  ADDR_SPAN = 32'h0000_0010
) (
    input  logic              clock,
    input  logic              reset,
    // core request / response port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [3:0]        wstrb_q,     wstrb_d;
    logic              awvalid_q,   awvalid_d;
    logic              wvalid_q,    wvalid_d;
    logic              arvalid_q,   arvalid_d;
    logic              bready_q,    bready_d;
    logic              rready_q,    rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              w_reject;

`ifdef AXIL_ADDR_CHECK_EN
    // Window bounds carry one extra bit so BASE_ADDR+ADDR_SPAN cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};
    logic [ADDR_W:0] w_addr_ext;
    assign w_addr_ext = {1'b0, req_addr};
    // Reject misaligned words and anything outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN).
    assign w_reject = (req_addr[1:0] != 2'b00) || (w_addr_ext < WIN_LO) || (w_addr_ext >= WIN_HI);
`else
    // Without the address check every request goes out on AXI.
    assign w_reject = 1'b0;
    logic w_unused_cfg;
    assign w_unused_cfg = ^{BASE_ADDR, ADDR_SPAN};
`endif

    // Only the error bit of the AXI response codes matters to the core.
    logic w_unused_resp;
    assign w_unused_resp = m_axi_bresp[0] ^ m_axi_rresp[0];

    assign req_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    // Next-state and next-output logic; every AXI output is precomputed here
    // so it leaves the block directly from a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (w_reject) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RA;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; move on once both are gone.
                awvalid_d = awvalid_q && !m_axi_awready;
                wvalid_d  = wvalid_q && !m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end
            end
            ST_WB: begin
                bready_d = 1'b1;
                if (m_axi_bvalid) begin
                    state_d     = ST_RESP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_axi_bresp[1];
                    rsp_rdata_d = '0;
                end
            end
            ST_RA: begin
                arvalid_d = arvalid_q && !m_axi_arready;
                if (!arvalid_d) begin
                    state_d  = ST_RD;
                    rready_d = 1'b1;
                end
            end
            ST_RD: begin
                rready_d = 1'b1;
                if (m_axi_rvalid) begin
                    state_d     = ST_RESP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_axi_rresp[1];
                    rsp_rdata_d = m_axi_rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_core_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_core_master_bridge
// Description : Directed bench for axil_core_master_bridge. A small register
//               slave model and a response scoreboard supply the expected
//               values; a compare process checks every response cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_core_master_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clock = ~clock;

    axil_core_master_bridge dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    logic [31:0] mem [0:3];
    bit          pend_m   = 1'b0;
    int          rsp_cnt  = 0;
    int          b_cnt    = 0;
    int          rsp_cyc  = 0;
    int          acc_cyc  = 0;
    int          aw_first = -1;
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;
    bit          hold_aw = 0, hold_w = 0, hold_ar = 0;
    logic [31:0] hold_awaddr, hold_wdata, hold_araddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Edge-side model: cycle count, outstanding flag, B count, valid stability.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            pend_m  = 1'b0;
            exp_q.delete();
            hold_aw = 0; hold_w = 0; hold_ar = 0;
        end else begin
            if (hold_aw) begin
                chk("awvalid_held", {31'd0, m_axi_awvalid}, 32'd1);
                chk("awaddr_stable", m_axi_awaddr, hold_awaddr);
            end
            if (hold_w) begin
                chk("wvalid_held", {31'd0, m_axi_wvalid}, 32'd1);
                chk("wdata_stable", m_axi_wdata, hold_wdata);
            end
            if (hold_ar) begin
                chk("arvalid_held", {31'd0, m_axi_arvalid}, 32'd1);
                chk("araddr_stable", m_axi_araddr, hold_araddr);
            end
            hold_aw = m_axi_awvalid && !m_axi_awready; hold_awaddr = m_axi_awaddr;
            hold_w  = m_axi_wvalid  && !m_axi_wready;  hold_wdata  = m_axi_wdata;
            hold_ar = m_axi_arvalid && !m_axi_arready; hold_araddr = m_axi_araddr;
            if (m_axi_bvalid && m_axi_bready) b_cnt++;
            if (pend_m && rsp_valid)      pend_m = 1'b0;
            else if (!pend_m && req_valid) pend_m = 1'b1;
        end
    end

    // Compare process: readiness, prot ties and every response against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !pend_m});
            chk("prot", {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc    = cyc;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input exp_t e);
        int t = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && t < 20) begin @(negedge clock); t++; end
        chk("accept", {31'd0, req_ready}, 32'd1);
        exp_q.push_back(e);
        acc_cyc = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int r0);
        int t = 0;
        while (rsp_cnt == r0 && t < 10) begin @(negedge clock); t++; end
        @(negedge clock);
        chk("rsp_count", rsp_cnt - r0, 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, input logic [1:0] br);
        exp_t e;
        int awc = 0, wc = 0, r0, b0;
        bit awh = 0, wh = 0, awj = 0, wj = 0, bdone = 0;
        logic [31:0] aw_a = '0, w_d = '0;
        logic [3:0]  w_s = '0;
        e.err = br[1]; e.rdata = '0;
        r0 = rsp_cnt; b0 = b_cnt; aw_first = -1;
        issue(1'b1, a, d, s, e);
        for (int t = 0; t < 60; t++) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0;
            if (bdone) begin m_axi_bvalid = 1'b0; break; end
            if (awh && wh && !m_axi_bvalid) begin m_axi_bvalid = 1'b1; m_axi_bresp = br; end
            if (m_axi_bvalid && m_axi_bready) begin
                bdone = 1;
                for (int k = 0; k < 4; k++)
                    if (w_s[k]) mem[aw_a[3:2]][8*k +: 8] = w_d[8*k +: 8];
            end
            if (awj) chk("awvalid_drop", {31'd0, m_axi_awvalid}, 32'd0);
            if (wj)  chk("wvalid_drop",  {31'd0, m_axi_wvalid},  32'd0);
            awj = 0; wj = 0;
            if (m_axi_awvalid && aw_first < 0) aw_first = cyc;
            if (m_axi_awvalid && !awh) begin
                if (awc >= awd) begin
                    m_axi_awready = 1'b1; awh = 1; awj = 1; aw_a = m_axi_awaddr;
                    chk("awaddr", m_axi_awaddr, a);
                end else awc++;
            end
            if (m_axi_wvalid && !wh) begin
                if (wc >= wd) begin
                    m_axi_wready = 1'b1; wh = 1; wj = 1; w_d = m_axi_wdata; w_s = m_axi_wstrb;
                    chk("wdata", m_axi_wdata, d);
                end else wc++;
            end
            @(negedge clock);
        end
        chk("write_b_done", {31'd0, bdone}, 32'd1);
        m_axi_bvalid = 1'b0;
        wait_rsp(r0);
        chk("b_count", b_cnt - b0, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, input int ard, input int rd,
                            input logic [1:0] rr, input bit ovr, input logic [31:0] od);
        exp_t e;
        int arc = 0, rc = 0, r0;
        bit arh = 0, arj = 0, rdone = 0;
        logic [31:0] ar_a = '0;
        e.err = rr[1]; e.rdata = ovr ? od : mem[a[3:2]];
        r0 = rsp_cnt;
        issue(1'b0, a, 32'd0, 4'd0, e);
        for (int t = 0; t < 60; t++) begin
            m_axi_arready = 1'b0;
            if (rdone) begin m_axi_rvalid = 1'b0; break; end
            if (arh && !m_axi_rvalid) begin
                if (rc >= rd) begin
                    m_axi_rvalid = 1'b1; m_axi_rresp = rr;
                    m_axi_rdata  = ovr ? od : mem[ar_a[3:2]];
                end else rc++;
            end
            if (m_axi_rvalid && m_axi_rready) rdone = 1;
            if (arj) chk("arvalid_drop", {31'd0, m_axi_arvalid}, 32'd0);
            arj = 0;
            if (m_axi_arvalid && !arh) begin
                if (arc >= ard) begin
                    m_axi_arready = 1'b1; arh = 1; arj = 1; ar_a = m_axi_araddr;
                    chk("araddr", m_axi_araddr, a);
                end else arc++;
            end
            @(negedge clock);
        end
        chk("read_r_done", {31'd0, rdone}, 32'd1);
        m_axi_rvalid = 1'b0;
        wait_rsp(r0);
    endtask

    initial begin
        int r0;
        exp_t e;
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rvalid = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valids", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 32'd0);
        chk("rst_readies", {30'd0, m_axi_bready, m_axi_rready}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_addr", m_axi_awaddr, 32'd0);
        chk("rst_wdata", m_axi_wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);

        // zero-wait write: AXI valid one cycle after accept, response three after
        axi_write(32'h0, 32'h1, 4'hF, 0, 0, 2'b00);
        chk("aw_latency", aw_first - acc_cyc, 32'd1);
        chk("rsp_latency", rsp_cyc - acc_cyc, 32'd3);
        chk("w1_err", {31'd0, last_err}, 32'd0);

        // four registers written then read back in order
        for (int i = 0; i < 4; i++) axi_write(32'(4 * i), 32'(i + 1), 4'hF, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            axi_read(32'(4 * i), 0, 0, 2'b00, 1'b0, 32'd0);
            chk("rd_literal", last_rdata, 32'(i + 1));
        end
        chk("rd_latency", rsp_cyc - acc_cyc, 32'd3);

        // W accepted three cycles before AW
        axi_write(32'h4, 32'hA5A5_0005, 4'hF, 3, 0, 2'b00);
        // AW accepted before W, slave returns SLVERR
        axi_write(32'h8, 32'h1234_5678, 4'hF, 0, 2, 2'b10);
        chk("slverr_w", {31'd0, last_err}, 32'd1);
        // partial strobe over the previous word
        axi_write(32'h8, 32'hFFFF_FFFF, 4'b0011, 1, 1, 2'b00);
        axi_read(32'h4, 2, 3, 2'b00, 1'b0, 32'd0);
        chk("rd_a5", last_rdata, 32'hA5A5_0005);
        axi_read(32'h8, 0, 1, 2'b00, 1'b0, 32'd0);
        chk("rd_strb", last_rdata, 32'h1234_FFFF);

        // read error keeps the returned data
        axi_read(32'hC, 0, 0, 2'b10, 1'b1, 32'hDEAD_BEEF);
        chk("rderr_err", {31'd0, last_err}, 32'd1);
        chk("rderr_data", last_rdata, 32'hDEAD_BEEF);

        // reset while waiting for B: no response may follow
        e.err = 1'b0; e.rdata = '0;
        r0 = rsp_cnt;
        issue(1'b1, 32'h0, 32'h55, 4'hF, e);
        for (int t = 0; t < 20; t++) begin
            m_axi_awready = m_axi_awvalid; m_axi_wready = m_axi_wvalid;
            if (m_axi_bready) break;
            @(negedge clock);
        end
        chk("wb_bready", {31'd0, m_axi_bready}, 32'd1);
        m_axi_awready = 0; m_axi_wready = 0;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_bready", {31'd0, m_axi_bready}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_valids", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_no_rsp", rsp_cnt - r0, 32'd0);
        axi_read(32'h0, 0, 0, 2'b00, 1'b0, 32'd0);
        chk("post_abort_rd", last_rdata, 32'h1);

`ifdef AXIL_ADDR_CHECK_EN
        // locally rejected reads never reach AXI
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ba;
            ba = (i == 0) ? 32'h2 : 32'h10;
            e.err = 1'b1; e.rdata = '0;
            r0 = rsp_cnt;
            issue(1'b0, ba, 32'd0, 4'd0, e);
            for (int t = 0; t < 6; t++) begin
                chk("rej_no_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
                @(negedge clock);
            end
            chk("rej_rsp", rsp_cnt - r0, 32'd1);
            chk("rej_err", {31'd0, last_err}, 32'd1);
            chk("rej_rdata", last_rdata, 32'd0);
        end
`endif

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
